// File: rtl/counters_pkg.sv
// Shared constants for the BCD counter family: digit width and default moduli.
package counters_pkg;
  localparam int DIGIT_W = 4;
  localparam int MOD6    = 6;
  localparam int MOD10   = 10;
  localparam int MOD60   = 60;
endpackage

// File: rtl/bcd_down_digit.sv
// Single decade down-counter digit with clamped parallel load and borrow-out on underflow.
module bcd_down_digit
  import counters_pkg::*;
#(
  parameter int MOD = MOD10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  input  logic               en,
  output logic [DIGIT_W-1:0] q,
  output logic               bo
);

  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MOD - 1);
  localparam logic [DIGIT_W-1:0] LIM = DIGIT_W'(MOD);

  function automatic logic [DIGIT_W-1:0] clamp(input logic [DIGIT_W-1:0] v);
    return (v > TOP) ? TOP : v;
  endfunction

  // Out-of-range values count as nonzero and land on MOD-2, back inside the legal range.
  function automatic logic [DIGIT_W-1:0] dec(input logic [DIGIT_W-1:0] v);
    if (v == '0)
      return TOP;
    else if (v >= LIM)
      return TOP - DIGIT_W'(1);
    else
      return v - DIGIT_W'(1);
  endfunction

  assign bo = en & (q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= clamp(d);
    else if (en)
      q <= dec(q);
  end

endmodule

// File: rtl/countdown_mod60.sv
// Two-digit cascadable BCD down-counter with optional wrap, zero flag and done pulse.
module countdown_mod60
  import counters_pkg::*;
#(
  parameter int TENS_MOD = MOD6,
  parameter int ONES_MOD = MOD10,
  parameter bit WRAP     = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d_tens,
  input  logic [DIGIT_W-1:0] d_ones,
  input  logic               en,
  output logic [DIGIT_W-1:0] q_tens,
  output logic [DIGIT_W-1:0] q_ones,
  output logic               bo,
  output logic               zero,
  output logic               done
);

  logic count_en;
  logic ones_bo;
  logic tens_bo;
  logic at_one;

  assign zero   = (q_tens == '0) && (q_ones == '0);
  assign at_one = (q_tens == '0) && (q_ones == DIGIT_W'(1));

  // Without wrap, 00 is terminal: suppress counting so neither digit rolls over.
  assign count_en = en & (WRAP | ~zero);

  bcd_down_digit #(.MOD(ONES_MOD)) u_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d     (d_ones),
    .en    (count_en),
    .q     (q_ones),
    .bo    (ones_bo)
  );

  bcd_down_digit #(.MOD(TENS_MOD)) u_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d     (d_tens),
    .en    (ones_bo),
    .q     (q_tens),
    .bo    (tens_bo)
  );

  assign bo = tens_bo & WRAP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done <= 1'b0;
    else
      done <= ~load & count_en & at_one;
  end

endmodule
